// File: rtl/lc3_io_device_if.sv
// Bus between the LC-3 memory controller and the keyboard/display device.
// The master drives the access; the device returns the window hit and read data.
interface lc3_io_device_if #(
   parameter int ADDRESS_BITS = 8
);
   logic [ADDRESS_BITS-1:0] addr;
   logic [15:0]             data_in;
   logic                    we;
   logic                    select;
   logic                    hit;
   logic [15:0]             data_out;

   modport master (
      output addr, data_in, we, select,
      input  hit, data_out
   );

   modport slave (
      input  addr, data_in, we, select,
      output hit, data_out
   );
endinterface

// File: rtl/lc3_io_device.sv
// LC-3 memory-mapped keyboard (KBSR/KBDR) and display (DSR/DDR) device.
// Define LC3_IO_INTERRUPT_EN to get a writable KBSR.IE and the registered irq.
module lc3_io_device #(
   parameter int                      ADDRESS_BITS        = 8,
   parameter logic [ADDRESS_BITS-1:0] BASE_ADDR           = 'hF0,
   parameter int                      DEBOUNCE_CYCLES     = 16,
   parameter int                      DISPLAY_BUSY_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   lc3_io_device_if.slave        bus,
   input  logic [9:0]            SW,
   input  logic [3:0]            KEY,
   output logic [15:0]           disp_value,
   output logic                  irq
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BW = $clog2(DISPLAY_BUSY_CYCLES + 1);

   logic [ADDRESS_BITS-1:0] off;
   logic acc, rd, wr;
   logic rd_kbdr, wr_kbsr, wr_dsr, wr_ddr;

   logic          key_s1_q, key_s2_q;
   logic          deb_q, deb_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic          press;
   logic          kb_rdy_q, kb_rdy_d;
   logic          kb_ovr_q, kb_ovr_d;
   logic [7:0]    kbdr_q, kbdr_d;
   logic          dsr_rdy_q, dsr_rdy_d;
   logic          dsr_err_q, dsr_err_d;
   logic [BW-1:0] busy_q, busy_d;
   logic [15:0]   disp_q, disp_d;
   logic          ie_rd;
   logic [15:0]   dout;
   logic          unused_ok;

   assign off     = bus.addr - BASE_ADDR;
   assign bus.hit = off < ADDRESS_BITS'(4);
   assign acc     = bus.select & bus.hit;
   assign rd      = acc & ~bus.we;
   assign wr      = acc & bus.we;
   assign rd_kbdr = rd & (off[1:0] == 2'd1);
   assign wr_kbsr = wr & (off[1:0] == 2'd0);
   assign wr_dsr  = wr & (off[1:0] == 2'd2);
   assign wr_ddr  = wr & (off[1:0] == 2'd3);

   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      press     = 1'b0;
      if (key_s2_q == deb_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES)) begin
         deb_d     = key_s2_q;
         deb_cnt_d = '0;
         // Levels differ, so committing while released means a press.
         press     = deb_q;
      end else begin
         deb_cnt_d = deb_cnt_q + 1'b1;
      end

      kb_rdy_d = kb_rdy_q;
      kb_ovr_d = kb_ovr_q;
      kbdr_d   = kbdr_q;
      if (press) begin
         kbdr_d   = SW[7:0];
         kb_rdy_d = 1'b1;
         kb_ovr_d = kb_rdy_q & ~rd_kbdr;
      end else if (rd_kbdr) begin
         kb_rdy_d = 1'b0;
         kb_ovr_d = 1'b0;
      end

      dsr_rdy_d = dsr_rdy_q;
      dsr_err_d = dsr_err_q;
      busy_d    = busy_q;
      disp_d    = disp_q;
      if (busy_q != '0) begin
         busy_d = busy_q - 1'b1;
         if (busy_q == BW'(1))
            dsr_rdy_d = 1'b1;
      end
      if (wr_ddr) begin
         if (dsr_rdy_q) begin
            disp_d    = bus.data_in;
            dsr_rdy_d = 1'b0;
            busy_d    = BW'(DISPLAY_BUSY_CYCLES);
         end else begin
            dsr_err_d = 1'b1;
         end
      end
      if (wr_dsr)
         dsr_err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_s1_q  <= 1'b1;
         key_s2_q  <= 1'b1;
         deb_q     <= 1'b1;
         deb_cnt_q <= '0;
         kb_rdy_q  <= 1'b0;
         kb_ovr_q  <= 1'b0;
         kbdr_q    <= '0;
         dsr_rdy_q <= 1'b1;
         dsr_err_q <= 1'b0;
         busy_q    <= '0;
         disp_q    <= '0;
      end else begin
         key_s1_q  <= KEY[1];
         key_s2_q  <= key_s1_q;
         deb_q     <= deb_d;
         deb_cnt_q <= deb_cnt_d;
         kb_rdy_q  <= kb_rdy_d;
         kb_ovr_q  <= kb_ovr_d;
         kbdr_q    <= kbdr_d;
         dsr_rdy_q <= dsr_rdy_d;
         dsr_err_q <= dsr_err_d;
         busy_q    <= busy_d;
         disp_q    <= disp_d;
      end
   end

`ifdef LC3_IO_INTERRUPT_EN
   logic ie_q, ie_d;
   logic irq_q;

   always_comb begin
      ie_d = ie_q;
      if (wr_kbsr)
         ie_d = bus.data_in[14];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ie_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         ie_q  <= ie_d;
         irq_q <= kb_rdy_q & ie_q;
      end
   end

   assign ie_rd = ie_q;
   assign irq   = irq_q;
`else
   assign ie_rd = 1'b0;
   assign irq   = 1'b0;
`endif

   always_comb begin
      dout = '0;
      if (bus.hit) begin
         case (off[1:0])
            2'd0: dout = {kb_rdy_q, ie_rd, kb_ovr_q, 13'b0};
            2'd1: dout = {8'b0, kbdr_q};
            2'd2: dout = {dsr_rdy_q, dsr_err_q, 14'b0};
            default: dout = disp_q;
         endcase
      end
   end

   assign bus.data_out = dout;
   assign disp_value   = disp_q;
   assign unused_ok    = ^{SW[9:8], KEY[3:2], KEY[0], wr_kbsr};
endmodule

// File: tb/tb_lc3_io_device.sv
// Self-checking bench for lc3_io_device: directed scenarios plus a
// randomized bus run checked against a time-based register model.
module tb_lc3_io_device;
   localparam int         DEB  = 16;
   localparam int         BUSY = 4;
   localparam logic [7:0] BASE = 8'hF0;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  SW;
   logic [3:0]  KEY;
   logic [15:0] disp_value;
   logic        irq;

   lc3_io_device_if #(.ADDRESS_BITS(8)) bus ();

   lc3_io_device #(
      .ADDRESS_BITS(8),
      .BASE_ADDR(BASE),
      .DEBOUNCE_CYCLES(DEB),
      .DISPLAY_BUSY_CYCLES(BUSY)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .SW(SW),
      .KEY(KEY),
      .disp_value(disp_value),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int edge_cnt = 0;

   // Model state
   bit         m_rdy, m_ovr, m_ie, m_err;
   logic [7:0] m_kbdr;
   logic [15:0] m_disp;
   int         m_free_at;

   task automatic cyc();
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic w,
                        input logic [7:0] a, input logic [15:0] d);
      bus.select  = s;
      bus.we      = w;
      bus.addr    = a;
      bus.data_in = d;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'($urandom), 16'($urandom));
   endtask

   task automatic model_reset();
      m_rdy = 0; m_ovr = 0; m_ie = 0; m_err = 0;
      m_kbdr = '0; m_disp = '0; m_free_at = 0;
   endtask

   function automatic logic [15:0] m_read(input logic [7:0] a);
      logic [7:0] o;
      bit ie;
      o = a - BASE;
`ifdef LC3_IO_INTERRUPT_EN
      ie = m_ie;
`else
      ie = 1'b0;
`endif
      if (o > 8'd3) return 16'h0000;
      case (o[1:0])
         2'd0: return {m_rdy, ie, m_ovr, 13'b0};
         2'd1: return {8'h00, m_kbdr};
         2'd2: return {edge_cnt >= m_free_at, m_err, 14'b0};
         default: return m_disp;
      endcase
   endfunction

   task automatic press_key(input logic [7:0] ch);
      SW = {2'($urandom), ch};
      KEY[1] = 1'b0;
      repeat (DEB + 4) cyc();
      KEY[1] = 1'b1;
      repeat (DEB + 4) cyc();
      m_ovr  = m_rdy;
      m_rdy  = 1'b1;
      m_kbdr = ch;
   endtask

   task automatic test_reset();
      logic [15:0] exp_v [4];
      exp_v[0] = 16'h0000; exp_v[1] = 16'h0000;
      exp_v[2] = 16'h8000; exp_v[3] = 16'h0000;
      reset = 1'b1;
      KEY = 4'hF;
      SW = 10'($urandom);
      idle();
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      model_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, BASE + 8'(i), 16'h0);
         n_tests++;
         if (bus.data_out !== exp_v[i] || bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_read[%0d] got %h hit=%b want %h hit=1",
                     i, bus.data_out, bus.hit, exp_v[i]);
         end
      end
      drive(1'b1, 1'b0, BASE - 8'd1, 16'h0);
      n_tests++;
      if (bus.hit !== 1'b0 || bus.data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_below_window hit=%b data=%h want 0/0000",
                  bus.hit, bus.data_out);
      end
      idle();
      n_tests++;
      if (irq !== 1'b0 || disp_value !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_outputs irq=%b disp=%h want 0/0000",
                  irq, disp_value);
      end
   endtask

   task automatic test_press_latency();
      logic [15:0] exp_s;
      idle();
      SW = 10'h041;
      KEY[1] = 1'b0;
      // After k cycles the bench is past edge n+k-1; ready appears after n+18.
      for (int k = 1; k <= 20; k++) begin
         cyc();
         exp_s = (k >= DEB + 3) ? 16'h8000 : 16'h0000;
         drive(1'b0, 1'b0, BASE, 16'h0);
         n_tests++;
         if (bus.data_out !== exp_s) begin
            n_fail++;
            $display("FAIL press_latency k=%0d KBSR got %h want %h",
                     k, bus.data_out, exp_s);
         end
      end
      KEY[1] = 1'b1;
      repeat (DEB + 4) cyc();
      drive(1'b1, 1'b0, BASE + 8'd1, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h0041) begin
         n_fail++;
         $display("FAIL press_kbdr got %h want 0041", bus.data_out);
      end
      cyc();
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL press_clear KBSR got %h want 0000", bus.data_out);
      end
      m_rdy = 0; m_ovr = 0; m_kbdr = 8'h41;
   endtask

   task automatic test_glitch_overrun();
      logic [7:0] c1;
      idle();
      KEY[1] = 1'b0;
      repeat (10) cyc();
      KEY[1] = 1'b1;
      repeat (DEB + 9) cyc();
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL glitch KBSR got %h want 0000", bus.data_out);
      end
      c1 = 8'($urandom);
      press_key(c1);
      press_key(8'h42);
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'hA000) begin
         n_fail++;
         $display("FAIL overrun KBSR got %h want a000", bus.data_out);
      end
      drive(1'b1, 1'b0, BASE + 8'd1, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h0042) begin
         n_fail++;
         $display("FAIL overrun KBDR got %h want 0042", bus.data_out);
      end
      cyc();
      m_rdy = 0; m_ovr = 0;
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL overrun_clear KBSR got %h want 0000", bus.data_out);
      end
   endtask

   task automatic test_same_edge();
      logic [7:0] c1, c2;
      c1 = 8'($urandom);
      c2 = c1 ^ 8'h5A;
      press_key(c1);
      idle();
      SW = {2'b00, c2};
      KEY[1] = 1'b0;
      repeat (DEB + 2) cyc();
      // This access ends on the commit edge n+18.
      drive(1'b1, 1'b0, BASE + 8'd1, 16'h0);
      n_tests++;
      if (bus.data_out !== {8'h00, c1}) begin
         n_fail++;
         $display("FAIL same_edge pre_read got %h want %h",
                  bus.data_out, {8'h00, c1});
      end
      cyc();
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h8000) begin
         n_fail++;
         $display("FAIL same_edge KBSR got %h want 8000", bus.data_out);
      end
      drive(1'b0, 1'b0, BASE + 8'd1, 16'h0);
      n_tests++;
      if (bus.data_out !== {8'h00, c2}) begin
         n_fail++;
         $display("FAIL same_edge KBDR got %h want %h",
                  bus.data_out, {8'h00, c2});
      end
      KEY[1] = 1'b1;
      repeat (DEB + 4) cyc();
      m_rdy = 1; m_ovr = 0; m_kbdr = c2;
   endtask

   task automatic test_display();
      logic [15:0] exp_d [5];
      exp_d[0] = 16'h0000; exp_d[1] = 16'h4000; exp_d[2] = 16'h0000;
      exp_d[3] = 16'h0000; exp_d[4] = 16'h8000;
      repeat (BUSY + 1) cyc();
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: drive(1'b1, 1'b1, BASE + 8'd3, 16'h1234);
            1: drive(1'b1, 1'b1, BASE + 8'd3, 16'h5678);
            2: drive(1'b1, 1'b1, BASE + 8'd2, 16'hFFFF);
            default: idle();
         endcase
         cyc();
         drive(1'b0, 1'b0, BASE + 8'd2, 16'h0);
         n_tests++;
         if (bus.data_out !== exp_d[k] || disp_value !== 16'h1234) begin
            n_fail++;
            $display("FAIL display k=%0d DSR=%h disp=%h want %h/1234",
                     k, bus.data_out, disp_value, exp_d[k]);
         end
      end
      drive(1'b1, 1'b1, BASE + 8'd3, 16'hBEEF);
      cyc();
      idle();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      model_reset();
      drive(1'b0, 1'b0, BASE + 8'd2, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h8000 || disp_value !== 16'h0000) begin
         n_fail++;
         $display("FAIL busy_reset DSR=%h disp=%h want 8000/0000",
                  bus.data_out, disp_value);
      end
   endtask

   task automatic test_random();
      logic [7:0]  a, o;
      logic [15:0] d, exp_v;
      logic        s, w;
      bit          in_win;
      for (int it = 0; it < 300; it++) begin
         if (it % 60 == 59) begin
            idle();
            press_key(8'($urandom));
         end
         in_win = ($urandom_range(0, 4) != 0);
         a = 8'($urandom);
         if (in_win) a = BASE + 8'($urandom_range(0, 3));
         else if (a >= BASE && a <= BASE + 8'd3) a = a ^ 8'h08;
         s = ($urandom_range(0, 4) != 0);
         w = 1'($urandom);
         d = 16'($urandom);
         drive(s, w, a, d);
         exp_v = m_read(a);
         n_tests++;
         if (bus.data_out !== exp_v || bus.hit !== in_win) begin
            n_fail++;
            $display("FAIL random it=%0d a=%h data=%h hit=%b want %h/%b",
                     it, a, bus.data_out, bus.hit, exp_v, in_win);
         end
         o = a - BASE;
         if (s && in_win) begin
            if (w) begin
               case (o[1:0])
                  2'd0: m_ie = d[14];
                  2'd2: m_err = 0;
                  2'd3: begin
                     if (edge_cnt >= m_free_at) begin
                        m_disp = d;
                        m_free_at = edge_cnt + 1 + BUSY;
                     end else m_err = 1;
                  end
                  default: ;
               endcase
            end else if (o[1:0] == 2'd1) begin
               m_rdy = 0;
               m_ovr = 0;
            end
         end
         cyc();
         n_tests++;
         if (disp_value !== m_disp) begin
            n_fail++;
            $display("FAIL random_disp it=%0d got %h want %h",
                     it, disp_value, m_disp);
         end
      end
      idle();
   endtask

   task automatic test_irq();
      idle();
      drive(1'b1, 1'b0, BASE + 8'd1, 16'h0);
      cyc();
      drive(1'b1, 1'b1, BASE, 16'h4000);
      cyc();
      idle();
      cyc();
`ifdef LC3_IO_INTERRUPT_EN
      SW = 10'h055;
      KEY[1] = 1'b0;
      repeat (DEB + 3) cyc();
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'hC000 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_ready KBSR=%h irq=%b want c000/0",
                  bus.data_out, irq);
      end
      cyc();
      n_tests++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_rise got %b want 1", irq);
      end
      KEY[1] = 1'b1;
      drive(1'b1, 1'b0, BASE + 8'd1, 16'h0);
      cyc();
      idle();
      n_tests++;
      if (irq !== 1'b1) begin
         n_fail++;
         $display("FAIL irq_hold got %b want 1", irq);
      end
      cyc();
      n_tests++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_fall got %b want 0", irq);
      end
      repeat (DEB + 4) cyc();
`else
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h0000) begin
         n_fail++;
         $display("FAIL ie_absent KBSR got %h want 0000", bus.data_out);
      end
      press_key(8'h55);
      drive(1'b0, 1'b0, BASE, 16'h0);
      n_tests++;
      if (bus.data_out !== 16'h8000 || irq !== 1'b0) begin
         n_fail++;
         $display("FAIL irq_off KBSR=%h irq=%b want 8000/0",
                  bus.data_out, irq);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_press_latency();
      test_glitch_overrun();
      test_same_edge();
      test_display();
      test_random();
      test_irq();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
